// File: rtl/qos_class_tracker.sv
// Per-class outstanding-transaction tracker with QoS type flags and a
// highest-priority-in-flight encoder. Optional error flags: QOS_CLASS_TRACKER_ERR_EN.
module qos_class_tracker #(
  parameter int QOS_CLASS_TYPE = 4,
  parameter int CNT_W          = 6,
  parameter int FLAG_MODE      = 1,
  localparam int CLS_W         = $clog2(QOS_CLASS_TYPE)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clean,
  input  logic                      inc_vld,
  input  logic [CLS_W-1:0]          inc_class,
  input  logic                      dec_vld,
  input  logic [CLS_W-1:0]          dec_class,
  output logic [QOS_CLASS_TYPE-1:0] type_flag,
  output logic [QOS_CLASS_TYPE-1:0] active_flag,
  output logic                      top_vld,
  output logic [CLS_W-1:0]          top_class,
  output logic [QOS_CLASS_TYPE-1:0] cnt_sat
`ifdef QOS_CLASS_TRACKER_ERR_EN
  ,
  output logic [QOS_CLASS_TYPE-1:0] err_ovf,
  output logic [QOS_CLASS_TYPE-1:0] err_udf
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // inc/dec are fire-and-forget pulses: each cycle with *_vld high is one
  // event, there is no ready/back-pressure and no event is ever stalled.
  logic                              inc_ok, dec_ok;
  logic [CNT_W-1:0]                  cnt_q [QOS_CLASS_TYPE];
  logic [CNT_W-1:0]                  cnt_d [QOS_CLASS_TYPE];
  logic [QOS_CLASS_TYPE-1:0]         type_flag_q, type_flag_d;
  logic [QOS_CLASS_TYPE-1:0]         ovf_new, udf_new;

  assign inc_ok = inc_vld && (32'(inc_class) < 32'(QOS_CLASS_TYPE));
  assign dec_ok = dec_vld && (32'(dec_class) < 32'(QOS_CLASS_TYPE));

  always_comb begin
    cnt_d   = cnt_q;
    ovf_new = '0;
    udf_new = '0;
    for (int i = 0; i < QOS_CLASS_TYPE; i++) begin
      logic inc_hit, dec_hit;
      inc_hit = inc_ok && (inc_class == CLS_W'(i));
      dec_hit = dec_ok && (dec_class == CLS_W'(i));
      // A matching inc/dec pair cancels, even at the count limits.
      if (inc_hit && !dec_hit) begin
        if (cnt_q[i] == CNT_MAX) ovf_new[i] = 1'b1;
        else                     cnt_d[i]   = cnt_q[i] + 1'b1;
      end else if (dec_hit && !inc_hit) begin
        if (cnt_q[i] == '0) udf_new[i] = 1'b1;
        else                cnt_d[i]   = cnt_q[i] - 1'b1;
      end
    end
  end

  always_comb begin
    type_flag_d = type_flag_q;
    if (clean) begin
      type_flag_d = '0;
    end else if (inc_ok) begin
      if (FLAG_MODE == 0) type_flag_d = '0;
      type_flag_d[inc_class] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QOS_CLASS_TYPE; i++) cnt_q[i] <= '0;
      type_flag_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      type_flag_q <= type_flag_d;
    end
  end

  always_comb begin
    active_flag = '0;
    cnt_sat     = '0;
    for (int i = 0; i < QOS_CLASS_TYPE; i++) begin
      active_flag[i] = (cnt_q[i] != '0);
      cnt_sat[i]     = (cnt_q[i] == CNT_MAX);
    end
  end

  always_comb begin
    top_class = '0;
    for (int i = 0; i < QOS_CLASS_TYPE; i++) begin
      if (active_flag[i]) top_class = CLS_W'(i);
    end
  end

  assign top_vld   = |active_flag;
  assign type_flag = type_flag_q;

`ifdef QOS_CLASS_TRACKER_ERR_EN
  logic [QOS_CLASS_TYPE-1:0] err_ovf_q, err_ovf_d, err_udf_q, err_udf_d;

  // A fresh error in the same cycle as clean survives the clear.
  always_comb begin
    err_ovf_d = (clean ? '0 : err_ovf_q) | ovf_new;
    err_udf_d = (clean ? '0 : err_udf_q) | udf_new;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_ovf_q <= '0;
      err_udf_q <= '0;
    end else begin
      err_ovf_q <= err_ovf_d;
      err_udf_q <= err_udf_d;
    end
  end

  assign err_ovf = err_ovf_q;
  assign err_udf = err_udf_q;
`else
  logic unused_err;
  assign unused_err = ^{ovf_new, udf_new};
`endif

endmodule

// File: tb/tb_qos_class_tracker.sv
// Bench for qos_class_tracker: directed scenarios plus random traffic against
// a counting reference model; one instance per flag mode on shared inputs.
module tb_qos_class_tracker;
  localparam int N    = 4;
  localparam int CW   = 3;
  localparam int MAXC = (1 << CW) - 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clean = 1'b0;
  logic       inc_vld = 1'b0;
  logic [1:0] inc_class = '0;
  logic       dec_vld = 1'b0;
  logic [1:0] dec_class = '0;

  logic [N-1:0] type_flag_a, active_a, sat_a, type_flag_b, active_b, sat_b;
  logic         top_vld_a, top_vld_b;
  logic [1:0]   top_class_a, top_class_b;
`ifdef QOS_CLASS_TRACKER_ERR_EN
  logic [N-1:0] err_ovf_a, err_udf_a, err_ovf_b, err_udf_b;
`endif

  qos_class_tracker #(.QOS_CLASS_TYPE(N), .CNT_W(CW), .FLAG_MODE(1)) u_sticky (
    .clk(clk), .rst_n(rst_n), .clean(clean),
    .inc_vld(inc_vld), .inc_class(inc_class),
    .dec_vld(dec_vld), .dec_class(dec_class),
    .type_flag(type_flag_a), .active_flag(active_a),
    .top_vld(top_vld_a), .top_class(top_class_a), .cnt_sat(sat_a)
`ifdef QOS_CLASS_TRACKER_ERR_EN
    , .err_ovf(err_ovf_a), .err_udf(err_udf_a)
`endif
  );

  qos_class_tracker #(.QOS_CLASS_TYPE(N), .CNT_W(CW), .FLAG_MODE(0)) u_onehot (
    .clk(clk), .rst_n(rst_n), .clean(clean),
    .inc_vld(inc_vld), .inc_class(inc_class),
    .dec_vld(dec_vld), .dec_class(dec_class),
    .type_flag(type_flag_b), .active_flag(active_b),
    .top_vld(top_vld_b), .top_class(top_class_b), .cnt_sat(sat_b)
`ifdef QOS_CLASS_TRACKER_ERR_EN
    , .err_ovf(err_ovf_b), .err_udf(err_udf_b)
`endif
  );

  // Clock
  always #5 clk = ~clk;

  // Reference model state: plain integer counts and flag bit-vectors.
  int           m_cnt [N];
  logic [N-1:0] m_sticky, m_onehot, m_ovf, m_udf;
  int           errors = 0;
  int           checks = 0;
  logic [7:0]   exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_sticky = '0; m_onehot = '0; m_ovf = '0; m_udf = '0;
  endtask

  task automatic model_step(input logic iv, input int ic, input logic dv, input int dc, input logic cl);
    logic [N-1:0] ovf, udf;
    ovf = '0; udf = '0;
    for (int i = 0; i < N; i++) begin
      int net;
      net = ((iv && ic == i) ? 1 : 0) - ((dv && dc == i) ? 1 : 0);
      if (net == 1) begin
        if (m_cnt[i] < MAXC) m_cnt[i]++; else ovf[i] = 1'b1;
      end else if (net == -1) begin
        if (m_cnt[i] > 0) m_cnt[i]--; else udf[i] = 1'b1;
      end
    end
    if (cl) begin
      m_sticky = '0; m_onehot = '0;
    end else if (iv) begin
      m_sticky = m_sticky | (N'(1) << ic);
      m_onehot = N'(1) << ic;
    end
    m_ovf = (cl ? '0 : m_ovf) | ovf;
    m_udf = (cl ? '0 : m_udf) | udf;
  endtask

  task automatic check_all(input string tag);
    logic [N-1:0] act, sat;
    int top;
    act = '0; sat = '0; top = 0;
    for (int i = 0; i < N; i++) begin
      act[i] = (m_cnt[i] != 0);
      sat[i] = (m_cnt[i] == MAXC);
      if (m_cnt[i] != 0) top = i;
    end
    check({tag, ".active"},    32'(active_a),    32'(act));
    check({tag, ".active_b"},  32'(active_b),    32'(act));
    check({tag, ".top_vld"},   32'(top_vld_a),   32'(act != 0));
    check({tag, ".top_class"}, 32'(top_class_a), 32'(top));
    check({tag, ".top_cls_b"}, 32'(top_class_b), 32'(top));
    check({tag, ".cnt_sat"},   32'(sat_a),       32'(sat));
    check({tag, ".flag_stk"},  32'(type_flag_a), 32'(m_sticky));
    check({tag, ".flag_1hot"}, 32'(type_flag_b), 32'(m_onehot));
`ifdef QOS_CLASS_TRACKER_ERR_EN
    check({tag, ".err_ovf"},   32'(err_ovf_a),   32'(m_ovf));
    check({tag, ".err_udf"},   32'(err_udf_a),   32'(m_udf));
    check({tag, ".err_ovf_b"}, 32'(err_ovf_b),   32'(m_ovf));
`endif
  endtask

  // Driver: one cycle of stimulus, model update at the edge, check #1 later.
  task automatic step(input string tag, input logic iv, input int ic,
                      input logic dv, input int dc, input logic cl);
    inc_vld = iv; inc_class = 2'(ic);
    dec_vld = dv; dec_class = 2'(dc);
    clean   = cl;
    @(posedge clk);
    model_step(iv, ic, dv, dc, cl);
    #1;
    inc_vld = 1'b0; dec_vld = 1'b0; clean = 1'b0;
    check_all(tag);
  endtask

  initial begin
    model_reset();
    // Reset block
    repeat (2) @(posedge clk);
    #1 check_all("reset");
    @(negedge clk) rst_n = 1'b1;

    // Reset mid-traffic
    for (int k = 0; k < 5; k++) step("fill2", 1'b1, 2, 1'b0, 0, 1'b0);
    @(negedge clk) rst_n = 1'b0;
    model_reset();
    #1 check_all("mid_rst");
    @(negedge clk) rst_n = 1'b1;
    step("post_rst", 1'b1, 1, 1'b0, 0, 1'b0);
    check("post_rst.active_lit", 32'(active_a), 32'h2);
    check("post_rst.top_lit", 32'(top_class_a), 32'd1);
    step("drain1", 1'b0, 0, 1'b1, 1, 1'b0);

    // Priority encode with an expected-queue of top_class values
    exp_q.push_back(8'd0); exp_q.push_back(8'd3); exp_q.push_back(8'd3);
    exp_q.push_back(8'd1); exp_q.push_back(8'd0); exp_q.push_back(8'd0);
    step("prio_i0", 1'b1, 0, 1'b0, 0, 1'b0); check("prio.seq0", 32'(top_class_a), 32'(exp_q.pop_front()));
    step("prio_i3", 1'b1, 3, 1'b0, 0, 1'b0); check("prio.seq1", 32'(top_class_a), 32'(exp_q.pop_front()));
    step("prio_i1", 1'b1, 1, 1'b0, 0, 1'b0); check("prio.seq2", 32'(top_class_a), 32'(exp_q.pop_front()));
    step("prio_d3", 1'b0, 0, 1'b1, 3, 1'b0); check("prio.seq3", 32'(top_class_a), 32'(exp_q.pop_front()));
    step("prio_d1", 1'b0, 0, 1'b1, 1, 1'b0); check("prio.seq4", 32'(top_class_a), 32'(exp_q.pop_front()));
    step("prio_d0", 1'b0, 0, 1'b1, 0, 1'b0); check("prio.seq5", 32'(top_class_a), 32'(exp_q.pop_front()));
    check("prio.top_vld_lit", 32'(top_vld_a), 32'd0);

    // Flag modes, then clean + inc in the same cycle
    step("flg_clr", 1'b0, 0, 1'b0, 0, 1'b1);
    step("flg_i2", 1'b1, 2, 1'b0, 0, 1'b0);
    step("flg_i0", 1'b1, 0, 1'b0, 0, 1'b0);
    check("flag.sticky_lit", 32'(type_flag_a), 32'h5);
    check("flag.onehot_lit", 32'(type_flag_b), 32'h1);
    step("flg_cl_i3", 1'b1, 3, 1'b0, 0, 1'b1);
    check("flag.clean_lit", 32'(type_flag_a), 32'h0);
    check("flag.cnt3_lit", 32'(active_a), 32'hD);
    step("flg_d0", 1'b0, 0, 1'b1, 0, 1'b0);
    step("flg_d2", 1'b0, 0, 1'b1, 2, 1'b0);
    step("flg_d3", 1'b0, 0, 1'b1, 3, 1'b0);

    // Simultaneous inc/dec
    step("sim_same0", 1'b1, 0, 1'b1, 0, 1'b0);
    step("sim_i2a", 1'b1, 2, 1'b0, 0, 1'b0);
    step("sim_i2b", 1'b1, 2, 1'b0, 0, 1'b0);
    step("sim_i1d2", 1'b1, 1, 1'b1, 2, 1'b0);
    check("sim.active_lit", 32'(active_a), 32'h6);
    step("sim_d2", 1'b0, 0, 1'b1, 2, 1'b0);
    step("sim_d1", 1'b0, 0, 1'b1, 1, 1'b0);

    // Saturation on class 0, including inc+dec at max
    for (int k = 0; k < MAXC + 1; k++) step("sat_inc", 1'b1, 0, 1'b0, 0, 1'b0);
    check("sat.flag_lit", 32'(sat_a[0]), 32'd1);
    step("sat_pair", 1'b1, 0, 1'b1, 0, 1'b0);
    step("sat_dec", 1'b0, 0, 1'b1, 0, 1'b0);
    check("sat.cleared_lit", 32'(sat_a[0]), 32'd0);
    step("sat_clean", 1'b0, 0, 1'b0, 0, 1'b1);
    for (int k = 0; k < MAXC - 1; k++) step("sat_drain", 1'b0, 0, 1'b1, 0, 1'b0);

    // Underflow on class 2, then error-wins-over-clean
    step("udf_d2", 1'b0, 0, 1'b1, 2, 1'b0);
    step("udf_clean", 1'b0, 0, 1'b0, 0, 1'b1);
    step("udf_cl_err", 1'b0, 0, 1'b1, 2, 1'b1);
    step("udf_clean2", 1'b0, 0, 1'b0, 0, 1'b1);

    // Random traffic: inc-heavy phase then dec-heavy phase
    for (int k = 0; k < 400; k++) begin
      logic iv, dv, cl;
      iv = ($urandom_range(0, 99) < ((k < 200) ? 75 : 30));
      dv = ($urandom_range(0, 99) < ((k < 200) ? 30 : 75));
      cl = ($urandom_range(0, 99) < 5);
      step("rand", iv, int'($urandom_range(0, N - 1)), dv, int'($urandom_range(0, N - 1)), cl);
    end

    // Report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $finish;
  end
endmodule

// File: doc/qos_class_tracker.md
Name: qos_class_tracker

Overview:
- Parametrised successor to the single-shot QoS type-flag register.
- Tracks per-class outstanding transactions with one up/down counter per QoS class.
- Keeps per-class type flags in two selectable modes: last-class one-hot or sticky accumulate.
- Reports the highest-priority class currently in flight; sits beside the NPU request scheduler, which issues increments on dispatch and decrements on completion.

Parameters:
- QOS_CLASS_TYPE, 4, number of QoS classes; class index = priority, higher index = higher priority; must be >= 2.
- CNT_W, 6, width of each per-class outstanding counter; max count = 2^CNT_W-1.
- FLAG_MODE, 1, 0 = one-hot last-class flag; 1 = sticky OR-accumulate of every class seen.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- clean  in  1  synchronous clear of type_flag (and of error flags when enabled).
- inc_vld  in  1  transaction dispatched with class inc_class.
- inc_class  in  $clog2(QOS_CLASS_TYPE)  class of the dispatched transaction.
- dec_vld  in  1  transaction completed with class dec_class.
- dec_class  in  $clog2(QOS_CLASS_TYPE)  class of the completed transaction.
- type_flag  out  QOS_CLASS_TYPE  per-class seen flags; format set by FLAG_MODE.
- active_flag  out  QOS_CLASS_TYPE  bit i = 1 iff cnt[i] != 0.
- top_vld  out  1  = |active_flag.
- top_class  out  $clog2(QOS_CLASS_TYPE)  highest i with active_flag[i]=1; 0 when top_vld=0.
- cnt_sat  out  QOS_CLASS_TYPE  bit i = 1 iff cnt[i] == 2^CNT_W-1.

Behaviour:
- Reset (rst_n low, any time, including mid-operation): all counters = 0 and type_flag = 0, so active_flag = 0, top_vld = 0, top_class = 0, cnt_sat = 0.
- Counters, one per class (cnt[i], CNT_W bits, registered):
  - inc only on class c: cnt[c] +1.
  - dec only on class c: cnt[c] -1.
  - inc and dec both on class c in the same cycle: cnt[c] unchanged (net zero), including at 0 and at max.
  - inc and dec on different classes in the same cycle: both applied independently.
  - Saturation: an inc to cnt[c] == max with no matching dec is dropped; cnt stays at max.
  - Underflow: a dec to cnt[c] == 0 with no matching inc is dropped; cnt stays at 0.
  - Out-of-range class index (> QOS_CLASS_TYPE-1, non-power-of-2 case): the event is ignored for counters and flags.
- type_flag (registered, updated only on inc_vld; dec does not affect it):
  - FLAG_MODE=0: on inc_vld, type_flag becomes one-hot of inc_class, replacing the previous value.
  - FLAG_MODE=1: on inc_vld, type_flag[inc_class] is set; other bits are held.
  - clean has priority over inc_vld for type_flag: type_flag = 0 the next cycle. The counter increment in that cycle still occurs.
  - clean never affects the counters.
- Latency: all outputs are combinational decodes of registered state, so an event at edge N is visible after edge N, i.e. 1 cycle.
- top_class is a priority encoder over active_flag, highest index wins. No arbitration state; no handshake back-pressure (inc/dec are fire-and-forget).

Optional Feature:
- Macro: QOS_CLASS_TRACKER_ERR_EN.
- Defined: adds ports err_ovf out QOS_CLASS_TYPE and err_udf out QOS_CLASS_TYPE.
  - Sticky per-class bits, set the cycle after a dropped inc (saturation) or dropped dec (underflow) on that class.
  - Cleared by reset or clean; if a new error and clean occur in the same cycle, the error bit is set (error wins).
- Undefined: ports absent; dropped events are silent; counters behave identically.

Test Plan:
- Reset mid-traffic: cnt[2]=5, assert rst_n low for 1 cycle -> all outputs 0 immediately; after release, inc class 1 -> active_flag=4'b0010, top_class=1, top_vld=1 one cycle later.
- Priority encode: inc classes 0,3,1 on successive cycles -> top_class sequence 0,3,3; dec class 3 -> top_class=1; dec 1, dec 0 -> top_vld=0, top_class=0.
- Flag modes: inc 2 then inc 0. FLAG_MODE=1 -> type_flag=4'b0101. FLAG_MODE=0 -> 4'b0001. clean+inc class 3 in the same cycle -> type_flag=0, cnt[3]=1.
- Simultaneous inc/dec: same class at cnt=0 -> stays 0, no err_udf. Class 1 inc with class 2 dec at cnt[2]=2 -> cnt[1]+1, cnt[2]=1.
- Saturation (CNT_W=2): 4 incs on class 0 -> cnt=3, cnt_sat[0]=1, and err_ovf[0]=1 when the macro is defined. One dec -> cnt=2, cnt_sat[0]=0, err_ovf[0] remains 1 until clean.
- Underflow: dec class 2 at cnt=0 -> cnt stays 0, err_udf[2]=1 (macro defined). Assert clean -> err_udf=0 next cycle.
